dsp_mac_pipe: RTL

Parametrised, handshaked multiply-accumulate pipeline. It is the streaming successor to the fixed-width DSP48A1-style slice: it keeps the pre-adder, multiplier and post-accumulator, and adds generic operand widths, per-sample op control, frame-based accumulation with a bias load, a sample counter, overflow flagging and valid/ready backpressure. It sits between a sample source (FIR/dot-product controller) and a result consumer.

---
 rtl/dsp_mac_pkg.sv | 25 ++
 rtl/dsp_acc_sat.sv | 51 +++++
 rtl/dsp_mac_pipe.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/dsp_mac_pkg.sv
// Shared definitions for the dsp_mac_pipe slice: OP field layout, op struct
// and the pre-adder width helper.
package dsp_mac_pkg;

    localparam int OP_USE_PRE = 0;
    localparam int OP_PRE_SUB = 1;
    localparam int OP_ACC_SUB = 2;
    localparam int OP_LAST    = 3;

    typedef struct packed {
        logic last;
        logic acc_sub;
        logic pre_sub;
        logic use_pre;
    } op_t;

    function automatic int pre_width(input int bw, input int dw);
        if (bw > dw) begin
            return bw + 32'sd1;
        end else begin
            return dw + 32'sd1;
        end
    endfunction

endpackage

// File: rtl/dsp_acc_sat.sv
// Signed PW-bit accumulate add/subtract with overflow detection.
// Build option DSP_MAC_SAT_EN: clamp the result to the signed range on overflow.
module dsp_acc_sat #(
    parameter int PW = 48
) (
    input  logic [PW-1:0] base,
    input  logic [PW-1:0] addend,
    input  logic          sub,
    output logic [PW-1:0] result,
    output logic          ovf
);

    logic [PW-1:0] raw_s;
    logic          same_sign_s;

    // Modular sum/difference; overflow when effective operand signs agree but the result sign differs
    always_comb begin
        raw_s       = {PW{1'b0}};
        same_sign_s = 1'b0;
        if (sub) begin
            raw_s       = base - addend;
            same_sign_s = (base[PW-1] != addend[PW-1]);
        end else begin
            raw_s       = base + addend;
            same_sign_s = (base[PW-1] == addend[PW-1]);
        end
        ovf = same_sign_s && (raw_s[PW-1] != base[PW-1]);
    end

`ifdef DSP_MAC_SAT_EN
    // An overflowed true result always carries the sign of base, so clamp toward it
    always_comb begin
        result = raw_s;
        if (ovf) begin
            if (base[PW-1]) begin
                result = {1'b1, {(PW-1){1'b0}}};
            end else begin
                result = {1'b0, {(PW-1){1'b1}}};
            end
        end else begin
            result = raw_s;
        end
    end
`else
    // Wrap modulo 2^PW
    always_comb begin
        result = raw_s;
    end
`endif

endmodule

// File: rtl/dsp_mac_pipe.sv
// Handshaked pre-add / multiply / frame-accumulate pipeline (S1 pre-add, S2 multiply, S3 accumulate).
// Build option DSP_MAC_SAT_EN selects clamping instead of wrapping on accumulator overflow.
module dsp_mac_pipe
    import dsp_mac_pkg::*;
#(
    parameter int AW = 18,
    parameter int BW = 18,
    parameter int DW = 18,
    parameter int PW = 48,
    parameter int CW = 16
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [AW-1:0] A,
    input  logic [BW-1:0] B,
    input  logic [DW-1:0] D,
    input  logic [PW-1:0] C,
    input  logic [3:0]    OP,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic [PW-1:0] P,
    output logic [CW-1:0] CNT,
    output logic          OVF
);

    localparam int XW = pre_width(BW, DW);
    localparam int MW = AW + XW;

    op_t                  op_in_s;
    logic signed [XW-1:0] b_ext_s, d_ext_s, pre_s;
    logic                 adv_s;

    logic                 s1_valid_r, s1_sub_r, s1_last_r;
    logic signed [AW-1:0] s1_a_r;
    logic signed [XW-1:0] s1_pre_r;
    logic [PW-1:0]        s1_c_r;

    logic signed [MW-1:0] m_s;
    logic                 s2_valid_r, s2_sub_r, s2_last_r;
    logic signed [MW-1:0] s2_m_r;
    logic [PW-1:0]        s2_c_r;

    logic [PW-1:0]        m_ext_s, base_s, acc_next_s, acc_r, p_r;
    logic                 acc_ovf_s, first_r, fovf_r, fovf_next_s;
    logic [CW-1:0]        cnt_r, cnt_next_s, cnt_out_r;
    logic                 out_valid_r, ovf_out_r;

    // The whole pipeline moves together; a held result freezes every stage
    assign adv_s     = !out_valid_r || OUT_READY;
    assign IN_READY  = adv_s;
    assign OUT_VALID = out_valid_r;
    assign P         = p_r;
    assign CNT       = cnt_out_r;
    assign OVF       = ovf_out_r;

    // Decode OP and form the full-width pre-adder result
    always_comb begin
        op_in_s         = op_t'(4'b0000);
        op_in_s.use_pre = OP[OP_USE_PRE];
        op_in_s.pre_sub = OP[OP_PRE_SUB];
        op_in_s.acc_sub = OP[OP_ACC_SUB];
        op_in_s.last    = OP[OP_LAST];
        b_ext_s         = XW'($signed(B));
        d_ext_s         = XW'($signed(D));
        pre_s           = b_ext_s;
        if (op_in_s.use_pre) begin
            if (op_in_s.pre_sub) begin
                pre_s = d_ext_s - b_ext_s;
            end else begin
                pre_s = d_ext_s + b_ext_s;
            end
        end else begin
            pre_s = b_ext_s;
        end
    end

    // S1 register: A, pre-adder result, bias and the op bits still needed downstream
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_valid_r <= 1'b0;
            s1_sub_r   <= 1'b0;
            s1_last_r  <= 1'b0;
            s1_a_r     <= {AW{1'b0}};
            s1_pre_r   <= {XW{1'b0}};
            s1_c_r     <= {PW{1'b0}};
        end else if (adv_s) begin
            s1_valid_r <= IN_VALID;
            s1_sub_r   <= op_in_s.acc_sub;
            s1_last_r  <= op_in_s.last;
            s1_a_r     <= A;
            s1_pre_r   <= pre_s;
            s1_c_r     <= C;
        end
    end

    // Full-precision signed product
    always_comb begin
        m_s = MW'(s1_a_r) * MW'(s1_pre_r);
    end

    // S2 register: product travels with its op bits and bias
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s2_valid_r <= 1'b0;
            s2_sub_r   <= 1'b0;
            s2_last_r  <= 1'b0;
            s2_m_r     <= {MW{1'b0}};
            s2_c_r     <= {PW{1'b0}};
        end else if (adv_s) begin
            s2_valid_r <= s1_valid_r;
            s2_sub_r   <= s1_sub_r;
            s2_last_r  <= s1_last_r;
            s2_m_r     <= m_s;
            s2_c_r     <= s1_c_r;
        end
    end

    // Accumulate operands, saturating sample count and frame overflow
    always_comb begin
        m_ext_s     = PW'(s2_m_r);
        base_s      = acc_r;
        cnt_next_s  = cnt_r;
        fovf_next_s = fovf_r | acc_ovf_s;
        if (first_r) begin
            base_s = s2_c_r;
        end else begin
            base_s = acc_r;
        end
        if (cnt_r == {CW{1'b1}}) begin
            cnt_next_s = cnt_r;
        end else begin
            cnt_next_s = cnt_r + CW'(1'b1);
        end
    end

    dsp_acc_sat #(
        .PW(PW)
    ) u_acc_sat (
        .base   (base_s),
        .addend (m_ext_s),
        .sub    (s2_sub_r),
        .result (acc_next_s),
        .ovf    (acc_ovf_s)
    );

    // S3: accumulator and frame state; LAST publishes the frame and rearms for the next one
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            acc_r       <= {PW{1'b0}};
            cnt_r       <= {CW{1'b0}};
            fovf_r      <= 1'b0;
            first_r     <= 1'b1;
            out_valid_r <= 1'b0;
            p_r         <= {PW{1'b0}};
            cnt_out_r   <= {CW{1'b0}};
            ovf_out_r   <= 1'b0;
        end else if (adv_s) begin
            if (s2_valid_r && s2_last_r) begin
                p_r         <= acc_next_s;
                cnt_out_r   <= cnt_next_s;
                ovf_out_r   <= fovf_next_s;
                out_valid_r <= 1'b1;
                acc_r       <= {PW{1'b0}};
                cnt_r       <= {CW{1'b0}};
                fovf_r      <= 1'b0;
                first_r     <= 1'b1;
            end else if (s2_valid_r) begin
                acc_r       <= acc_next_s;
                cnt_r       <= cnt_next_s;
                fovf_r      <= fovf_next_s;
                first_r     <= 1'b0;
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= 1'b0;
            end
        end
    end

endmodule
